// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch stage feeding the decoder.
// Keeps the fetch PC and issues aligned 64-bit reads, with at most one read
// outstanding. Each response is split into two 32-bit instructions, which are
// queued with their PCs in a small FIFO. The FIFO head is presented to the
// decoder over a valid/ready handshake. A redirect flushes everything in flight.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   redirect_valid, redirect_pc     restart fetch at redirect_pc (bits[1:0] ignored)
//   mem_req_valid/ready/addr        read request channel (8-byte aligned address)
//   mem_resp_valid/data             read response (single-cycle, little-endian)
//   instr_valid/ready, instr,       FIFO head presented to the decoder
//   instr_pc
//   perf_stall, perf_fetched        only present when FETCH_PERF_EN is defined
//
// Optional feature macro: FETCH_PERF_EN (stall / fetched-instruction counters).
module fetch_buffer #(
  parameter int unsigned       ADDRSZ   = 64,
  parameter int unsigned       INSTRSZ  = 32,
  parameter int unsigned       BUSSZ    = 64,
  parameter int unsigned       DEPTH    = 8,
  parameter logic [ADDRSZ-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDRSZ-1:0]  redirect_pc,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDRSZ-1:0]  mem_req_addr,
  input  logic               mem_resp_valid,
  input  logic [BUSSZ-1:0]   mem_resp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTRSZ-1:0] instr,
  output logic [ADDRSZ-1:0]  instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall,
  output logic [31:0]        perf_fetched
`endif
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [ADDRSZ-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_slot1;
  logic [CNTW-1:0]     count_q, count_d, enq_n;
  logic [INSTRSZ-1:0]  fifo_instr [DEPTH];
  logic [ADDRSZ-1:0]   fifo_pc    [DEPTH];

  logic                accept, deq, take;
  logic                we0, we1;
  logic [INSTRSZ-1:0]  wdata0, wdata1;
  logic [ADDRSZ-1:0]   wpc0, wpc1;
  logic                mem_req_valid_d;
  logic [ADDRSZ-1:0]   mem_req_addr_d;
  logic [INSTRSZ-1:0]  instr_d;
  logic [ADDRSZ-1:0]   instr_pc_d;

  // Redirect targets are word aligned; the low two bits carry no information.
  logic [1:0] unused_redirect_lsbs;
  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Next-state, FIFO bookkeeping and next values of the registered outputs.
  always_comb begin : next_state
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    enq_n      = '0;
    we0        = 1'b0;
    we1        = 1'b0;
    wdata0     = '0;
    wdata1     = '0;
    wpc0       = '0;
    wpc1       = '0;
    accept     = mem_req_valid & mem_req_ready;
    deq        = instr_valid & instr_ready & ~redirect_valid;
    take       = (state_q == WAIT) & mem_resp_valid & ~redirect_valid;
    wr_slot1   = wr_ptr_q + PTRW'(1);

    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (accept) state_d = WAIT;
      WAIT:    if (mem_resp_valid) state_d = REQ;
      FLUSH:   if (mem_resp_valid) state_d = REQ;
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDRSZ-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // A response arriving with the redirect retires the outstanding read,
      // so there is nothing left to drain and fetch can restart directly.
      case (state_q)
        IDLE:        state_d = REQ;
        REQ:         state_d = accept ? FLUSH : REQ;
        WAIT, FLUSH: state_d = mem_resp_valid ? REQ : FLUSH;
        default:     state_d = IDLE;
      endcase
    end else begin
      if (take) begin
        if (fetch_pc_q[2]) begin
          // Upper-half entry: only the second instruction of the word is wanted.
          we0        = 1'b1;
          wdata0     = mem_resp_data[BUSSZ-1:INSTRSZ];
          wpc0       = fetch_pc_q;
          enq_n      = CNTW'(1);
          fetch_pc_d = fetch_pc_q + ADDRSZ'(4);
        end else begin
          we0        = 1'b1;
          we1        = 1'b1;
          wdata0     = mem_resp_data[INSTRSZ-1:0];
          wpc0       = fetch_pc_q;
          wdata1     = mem_resp_data[BUSSZ-1:INSTRSZ];
          wpc1       = fetch_pc_q + ADDRSZ'(4);
          enq_n      = CNTW'(2);
          fetch_pc_d = fetch_pc_q + ADDRSZ'(8);
        end
      end
      wr_ptr_d = wr_ptr_q + PTRW'(enq_n);
      rd_ptr_d = rd_ptr_q + PTRW'(deq);
      count_d  = count_q + enq_n - CNTW'(deq);
    end

    // Requests only go out when a full response is guaranteed to fit.
    mem_req_valid_d = (state_d == REQ) && (count_d <= CNTW'(DEPTH - 2));
    mem_req_addr_d  = {fetch_pc_d[ADDRSZ-1:3], 3'b000};

    // Next head, bypassing entries that are being written this cycle.
    instr_d    = fifo_instr[rd_ptr_d];
    instr_pc_d = fifo_pc[rd_ptr_d];
    if (we1 && (wr_slot1 == rd_ptr_d)) begin
      instr_d    = wdata1;
      instr_pc_d = wpc1;
    end
    if (we0 && (wr_ptr_q == rd_ptr_d)) begin
      instr_d    = wdata0;
      instr_pc_d = wpc0;
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      instr_valid   <= 1'b0;
      instr         <= '0;
      instr_pc      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      mem_req_valid <= mem_req_valid_d;
      mem_req_addr  <= mem_req_addr_d;
      instr_valid   <= (count_d != '0);
      instr         <= instr_d;
      instr_pc      <= instr_pc_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin : fifo_store
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr[PTRW'(i)] <= '0;
        fifo_pc[PTRW'(i)]    <= '0;
      end
    end else begin
      if (we0) begin
        fifo_instr[wr_ptr_q] <= wdata0;
        fifo_pc[wr_ptr_q]    <= wpc0;
      end
      if (we1) begin
        fifo_instr[wr_slot1] <= wdata1;
        fifo_pc[wr_slot1]    <= wpc1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Starved-decoder cycles and delivered instructions.
  always_ff @(posedge clk or negedge rst_n) begin : perf_cnt
    if (!rst_n) begin
      perf_stall   <= '0;
      perf_fetched <= '0;
    end else begin
      if (!instr_valid) perf_stall <= perf_stall + 32'd1;
      if (deq)          perf_fetched <= perf_fetched + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios and randomized
// traffic compared against a queue-based reference model of the fetch stage.
module tb_fetch_buffer;

  localparam int unsigned ADDRSZ  = 64;
  localparam int unsigned INSTRSZ = 32;
  localparam int unsigned BUSSZ   = 64;
  localparam int unsigned DEPTH   = 8;
  localparam logic [63:0] RPC     = 64'h1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_fetched;
`endif

  always #5 clk = ~clk;

  fetch_buffer #(
    .ADDRSZ(ADDRSZ), .INSTRSZ(INSTRSZ), .BUSSZ(BUSSZ), .DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
    , .perf_stall(perf_stall), .perf_fetched(perf_fetched)
`endif
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] pc;
  } ent_t;

  // Reference model: expected FIFO contents and fetch bookkeeping.
  ent_t        q[$];
  bit          boot, pending, discard;
  logic [63:0] fpc;
  int unsigned m_stall, m_fetched;

  // Bench-side memory and stimulus knobs.
  bit          busy;
  int unsigned cnt;
  int unsigned lat_min = 1, lat_max = 1;
  int unsigned p_redir = 0, p_rdy = 100, p_mrdy = 100, p_spur = 0;
  bit          fixed = 1'b0;
  logic [63:0] fixed_word = '0;
  int unsigned n_acc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_mv();
    return !boot && !pending && (q.size() <= int'(DEPTH) - 2);
  endfunction

  task automatic model_reset();
    q.delete();
    boot = 1'b1; pending = 1'b0; discard = 1'b0;
    fpc = RPC; m_stall = 0; m_fetched = 0;
  endtask

  // One clock edge of the fetch stage, expressed as queue operations.
  task automatic model_step(input bit rv, input logic [63:0] rpc, input bit irdy,
                            input bit mrdy, input bit rsv, input logic [63:0] rsd);
    bit   mv, iv;
    ent_t e;
    mv = m_mv();
    iv = (q.size() != 0);
    if (!iv) m_stall++;
    if (rv) begin
      q.delete();
      if (pending) begin
        if (rsv) begin pending = 1'b0; discard = 1'b0; end
        else discard = 1'b1;
      end else if (mv && mrdy) begin
        pending = 1'b1; discard = 1'b1;
      end
      boot = 1'b0;
      fpc  = {rpc[63:2], 2'b00};
    end else begin
      if (iv && irdy) begin void'(q.pop_front()); m_fetched++; end
      if (boot) boot = 1'b0;
      else if (mv && mrdy) begin pending = 1'b1; discard = 1'b0; end
      else if (pending && rsv) begin
        pending = 1'b0;
        if (discard) discard = 1'b0;
        else if (fpc[2]) begin
          e.ins = rsd[63:32]; e.pc = fpc; q.push_back(e);
          fpc = fpc + 64'd4;
        end else begin
          e.ins = rsd[31:0];  e.pc = fpc;         q.push_back(e);
          e.ins = rsd[63:32]; e.pc = fpc + 64'd4; q.push_back(e);
          fpc = fpc + 64'd8;
        end
      end
    end
  endtask

  task automatic mem_advance(input bit acc);
    if (busy) begin
      if (cnt <= 1) busy = 1'b0;
      else cnt--;
    end
    if (acc) begin
      busy = 1'b1;
      cnt  = $urandom_range(lat_max, lat_min);
    end
  endtask

  // Drive all inputs for the coming edge (called just after a falling edge).
  task automatic drive();
    redirect_valid = ($urandom_range(99) < p_redir);
    redirect_pc    = ($urandom_range(7) == 0) ? {32'hFFFF_FFFF, $urandom} : {$urandom, $urandom};
    instr_ready    = ($urandom_range(99) < p_rdy);
    mem_req_ready  = !busy && ($urandom_range(99) < p_mrdy);
    if (busy && cnt == 1) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = fixed ? fixed_word : {$urandom, $urandom};
    end else begin
      mem_resp_valid = !busy && ($urandom_range(99) < p_spur);
      mem_resp_data  = {$urandom, $urandom};
    end
  endtask

  task automatic check_outputs();
    bit mv, iv;
    mv = m_mv();
    iv = (q.size() != 0);
    chk("mem_req_valid", 64'(mem_req_valid), 64'(mv));
    if (mv) chk("mem_req_addr", mem_req_addr, {fpc[63:3], 3'b000});
    chk("instr_valid", 64'(instr_valid), 64'(iv));
    if (iv) begin
      chk("instr", 64'(instr), 64'(q[0].ins));
      chk("instr_pc", instr_pc, q[0].pc);
    end
`ifdef FETCH_PERF_EN
    chk("perf_stall", 64'(perf_stall), 64'(m_stall));
    chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
`endif
  endtask

  // Check, then advance DUT, memory and model by one clock.
  task automatic tick();
    bit          acc, rv, irdy, mrdy, rsv;
    logic [63:0] rpc, rsd;
    check_outputs();
    acc  = mem_req_valid && mem_req_ready;
    rv   = redirect_valid; rpc = redirect_pc; irdy = instr_ready;
    mrdy = mem_req_ready;  rsv = mem_resp_valid; rsd = mem_resp_data;
    @(posedge clk);
    if (acc) n_acc++;
    mem_advance(acc);
    model_step(rv, rpc, irdy, mrdy, rsv, rsd);
    @(negedge clk);
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_req_addr"}, mem_req_addr, 64'd0);
    chk({tag, "_instr_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, "_instr"}, 64'(instr), 64'd0);
    chk({tag, "_instr_pc"}, instr_pc, 64'd0);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_stall"}, 64'(perf_stall), 64'd0);
    chk({tag, "_perf_fetched"}, 64'(perf_fetched), 64'd0);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      tick();
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; instr_ready = 1'b0;
    busy = 1'b0; cnt = 0; n_acc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_zero("reset");
    rst_n = 1'b1;

    // Basic fetch from RESET_PC with a two-cycle memory.
    lat_min = 2; lat_max = 2; fixed = 1'b1; fixed_word = 64'h00500093_00000013;
    run(14);

    // Redirect to an upper-half address: only the high instruction is queued.
    fixed_word = 64'hAAAAAAAA_BBBBBBBB;
    drive(); redirect_valid = 1'b1; redirect_pc = 64'h2004;
    tick();
    run(14);

    // Decoder stalled, single-cycle memory: FIFO fills and requests stop.
    fixed = 1'b0; lat_min = 1; lat_max = 1; p_rdy = 0;
    drive(); redirect_valid = 1'b1; redirect_pc = 64'h5000;
    tick();
    n_acc = 0;
    run(30);
    chk("req_count_full", 64'(n_acc), 64'd4);
    p_rdy = 100; run(1);
    p_rdy = 0;   run(1);
    chk("no_req_one_free", 64'(mem_req_valid), 64'd0);
    p_rdy = 100; run(1);
    chk("req_two_free", 64'(mem_req_valid), 64'd1);

    // Redirect while waiting with six instructions queued.
    lat_min = 6; lat_max = 6; p_rdy = 0;
    drive(); redirect_valid = 1'b1; redirect_pc = 64'h6000;
    tick();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (busy && q.size() == 6) found = 1'b1;
      else run(1);
    end
    chk("wait_six_queued", 64'(found), 64'd1);
    drive(); redirect_valid = 1'b1; redirect_pc = 64'h3000;
    tick();
    chk("flush_instr_valid", 64'(instr_valid), 64'd0);
    lat_min = 2; lat_max = 2; p_rdy = 100;
    run(20);

    // Asynchronous reset in WAIT with three queued; a stale response follows.
    lat_min = 4; lat_max = 4; p_rdy = 0;
    drive(); redirect_valid = 1'b1; redirect_pc = 64'h4004;
    tick();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (busy && q.size() == 3) found = 1'b1;
      else run(1);
    end
    chk("wait_three_queued", 64'(found), 64'd1);
    drive(); mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_zero("async_reset");
    model_reset();
    @(posedge clk); mem_advance(1'b0);
    @(negedge clk); drive(); mem_req_ready = 1'b0;
    @(posedge clk); mem_advance(1'b0);
    @(negedge clk);
    check_reset_zero("held_reset");
    rst_n = 1'b1;
    p_rdy = 100;
    run(20);

    // Randomized traffic: redirects, stalls, spurious responses, varied latency.
    lat_min = 1; lat_max = 4; p_redir = 4; p_rdy = 70; p_mrdy = 60; p_spur = 10;
    run(2500);
    p_rdy = 20; p_redir = 2;
    run(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
